// File: rtl/branch_cond_unit.sv
// branch_cond_unit
//   Resolves conditional branches against the ALU flags. A registered copy of
//   ZF/EQF/GTF/SF is kept; a flag-setting instruction in the same cycle as the
//   branch bypasses the copy. A taken branch raises BR_TAKEN/BR_ADDR for one
//   cycle and holds FLUSH/BUSY for FLUSH_DEPTH enabled cycles.
//
// Ports
//   CLK, RESET_N           clock (rising edge), async active-low reset
//   ENABLE                 pipeline advance; low freezes every register
//   ZF, EQF, GTF, SF       incoming flags, qualified by FLAG_VALID
//   BR_REQ, BR_COND        branch present this cycle and its condition code
//   BR_TARGET              branch destination
//   BR_TAKEN, BR_ADDR      registered taken pulse and its target
//   BR_DONE                registered resolution pulse (taken or not)
//   FLUSH, BUSY            squash younger stages while flushing
//   TAKEN_CNT              saturating count of taken branches
module branch_cond_unit #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic                 ZF,
  input  logic                 EQF,
  input  logic                 GTF,
  input  logic                 SF,
  input  logic                 FLAG_VALID,
  input  logic                 BR_REQ,
  input  logic [3:0]           BR_COND,
  input  logic [PC_WIDTH-1:0]  BR_TARGET,
  output logic                 BR_TAKEN,
  output logic [PC_WIDTH-1:0]  BR_ADDR,
  output logic                 BR_DONE,
  output logic                 FLUSH,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] TAKEN_CNT
);

  localparam int unsigned FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             flags_q, flags_d;     // {Z, EQ, GT, S}
  logic                   br_taken_q, br_taken_d;
  logic                   br_done_q, br_done_d;
  logic [PC_WIDTH-1:0]    br_addr_q, br_addr_d;
  logic [FC_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0]   taken_cnt_q, taken_cnt_d;

  logic [3:0]             eff_flags;
  logic                   cond_met;

  // Same-cycle flags win over the stored copy.
  assign eff_flags = FLAG_VALID ? {ZF, EQF, GTF, SF} : flags_q;

  always_comb begin
    cond_met = 1'b0;
    unique case (BR_COND)
      4'd0:    cond_met = 1'b1;
      4'd1:    cond_met = eff_flags[3];
      4'd2:    cond_met = ~eff_flags[3];
      4'd3:    cond_met = eff_flags[2];
      4'd4:    cond_met = ~eff_flags[2];
      4'd5:    cond_met = eff_flags[1];
      4'd6:    cond_met = ~eff_flags[1];
      4'd7:    cond_met = eff_flags[0];
      4'd8:    cond_met = ~eff_flags[0];
      4'd9:    cond_met = eff_flags[1] | eff_flags[2];
      4'd10:   cond_met = ~eff_flags[1] & ~eff_flags[2];
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    br_taken_d  = br_taken_q;
    br_done_d   = br_done_q;
    br_addr_d   = br_addr_q;
    flush_cnt_d = flush_cnt_q;
    taken_cnt_d = taken_cnt_q;

    if (ENABLE) begin
      br_taken_d = 1'b0;
      br_done_d  = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (FLAG_VALID) begin
            flags_d = {ZF, EQF, GTF, SF};
          end
          if (BR_REQ) begin
            br_done_d  = 1'b1;
            br_taken_d = cond_met;
            if (cond_met) begin
              br_addr_d   = BR_TARGET;
              flush_cnt_d = FC_LOAD;
              state_d     = ST_FLUSH;
              if (taken_cnt_q != '1) begin
                taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
              end
            end
          end
        end
        ST_FLUSH: begin
          // Requests and flags arriving here belong to squashed instructions.
          if (flush_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      br_taken_q  <= 1'b0;
      br_done_q   <= 1'b0;
      br_addr_q   <= '0;
      flush_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      br_taken_q  <= br_taken_d;
      br_done_q   <= br_done_d;
      br_addr_q   <= br_addr_d;
      flush_cnt_q <= flush_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // FLUSH and BUSY are both the registered FLUSH state, so they rise with
  // BR_TAKEN and stay up for FLUSH_DEPTH enabled cycles.
  assign FLUSH     = (state_q == ST_FLUSH);
  assign BUSY      = (state_q == ST_FLUSH);
  assign BR_TAKEN  = br_taken_q;
  assign BR_DONE   = br_done_q;
  assign BR_ADDR   = br_addr_q;
  assign TAKEN_CNT = taken_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: default build plus a CNT_WIDTH=2 build for
// counter saturation. Expected resolutions are queued as branches are driven
// and popped when the DUT resolves them.
module tb_branch_cond_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b1;
  logic        ZF = 1'b0, EQF = 1'b0, GTF = 1'b0, SF = 1'b0;
  logic        FLAG_VALID = 1'b0;
  logic        BR_REQ = 1'b0;
  logic [3:0]  BR_COND = '0;
  logic [9:0]  BR_TARGET = '0;
  logic        BR_TAKEN, BR_DONE, FLUSH, BUSY;
  logic [9:0]  BR_ADDR;
  logic [15:0] TAKEN_CNT;
  logic        sm_taken, sm_done, sm_flush, sm_busy;
  logic [9:0]  sm_addr;
  logic [1:0]  sm_cnt;

  branch_cond_unit #(.PC_WIDTH(10), .FLUSH_DEPTH(3), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .ZF(ZF), .EQF(EQF), .GTF(GTF), .SF(SF), .FLAG_VALID(FLAG_VALID),
    .BR_REQ(BR_REQ), .BR_COND(BR_COND), .BR_TARGET(BR_TARGET),
    .BR_TAKEN(BR_TAKEN), .BR_ADDR(BR_ADDR), .BR_DONE(BR_DONE),
    .FLUSH(FLUSH), .BUSY(BUSY), .TAKEN_CNT(TAKEN_CNT)
  );

  branch_cond_unit #(.PC_WIDTH(10), .FLUSH_DEPTH(3), .CNT_WIDTH(2)) dut_sm (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .ZF(ZF), .EQF(EQF), .GTF(GTF), .SF(SF), .FLAG_VALID(FLAG_VALID),
    .BR_REQ(BR_REQ), .BR_COND(BR_COND), .BR_TARGET(BR_TARGET),
    .BR_TAKEN(sm_taken), .BR_ADDR(sm_addr), .BR_DONE(sm_done),
    .FLUSH(sm_flush), .BUSY(sm_busy), .TAKEN_CNT(sm_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       taken;
    logic [9:0] addr;
    int         cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] m_flags = '0;   // {Z, EQ, GT, S}
  logic [9:0] m_addr = '0;
  int         m_cnt = 0;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic z, e, g, s;
    {z, e, g, s} = f;
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return e;
      4'd4:  return !e;
      4'd5:  return g;
      4'd6:  return !g;
      4'd7:  return s;
      4'd8:  return !s;
      4'd9:  return g || e;
      4'd10: return !g && !e;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    BR_REQ = 1'b0; FLAG_VALID = 1'b0; BR_COND = '0; BR_TARGET = '0;
    {ZF, EQF, GTF, SF} = 4'b0000;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic reset_model();
    m_flags = '0; m_addr = '0; m_cnt = 0; sb.delete();
  endtask

  task automatic set_flags(input logic [3:0] f);
    BR_REQ = 1'b0; FLAG_VALID = 1'b1; {ZF, EQF, GTF, SF} = f;
    m_flags = f;
  endtask

  // Drives one branch in IDLE and queues its expected resolution.
  task automatic issue(input logic [3:0] c, input logic [9:0] t,
                       input logic fv, input logic [3:0] f);
    exp_t       e;
    logic [3:0] eff;
    eff = fv ? f : m_flags;
    if (fv) m_flags = f;
    BR_REQ = 1'b1; BR_COND = c; BR_TARGET = t; FLAG_VALID = fv;
    {ZF, EQF, GTF, SF} = f;
    e.taken = cond_ok(c, eff);
    if (e.taken) begin
      m_addr = t;
      m_cnt++;
    end
    e.addr = m_addr;
    e.cnt  = (m_cnt > 65535) ? 65535 : m_cnt;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    repeat (2) tick();
    n_checks++;
    if ({BR_TAKEN, BR_ADDR, BR_DONE, FLUSH, BUSY, TAKEN_CNT} !== '0)
      $display("FAIL reset_init: got taken=%b addr=%h done=%b flush=%b busy=%b cnt=%0d, want all 0",
               BR_TAKEN, BR_ADDR, BR_DONE, FLUSH, BUSY, TAKEN_CNT);
    else n_pass++;
    RESET_N = 1'b1;
    issue(4'd0, 10'h0AB, 1'b0, 4'b0000);
    tick();
    idle();
    void'(sb.pop_front());
    tick();
    #2 RESET_N = 1'b0;
    reset_model();
    #1;
    n_checks++;
    if ({BR_TAKEN, BR_ADDR, BR_DONE, FLUSH, BUSY, TAKEN_CNT, sm_flush, sm_cnt} !== '0)
      $display("FAIL reset_midflush: got taken=%b addr=%h done=%b flush=%b busy=%b cnt=%0d, want all 0",
               BR_TAKEN, BR_ADDR, BR_DONE, FLUSH, BUSY, TAKEN_CNT);
    else n_pass++;
    tick();
    RESET_N = 1'b1;
    issue(4'd0, 10'h055, 1'b0, 4'b0000);
    tick();
    idle();
    e = sb.pop_front();
    n_checks++;
    if ({BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT} !== {1'b1, e.taken, e.addr, 16'(e.cnt)})
      $display("FAIL reset_release_branch: got done=%b taken=%b addr=%h cnt=%0d, want 1 %b %h %0d",
               BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, e.taken, e.addr, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_bypass();
    exp_t e;
    int   hi;
    issue(4'd1, 10'h120, 1'b1, 4'b1000);
    tick();
    idle();
    e = sb.pop_front();
    n_checks++;
    if ({BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT} !== {1'b1, e.taken, e.addr, 16'(e.cnt)} || !e.taken)
      $display("FAIL bypass_resolve: got done=%b taken=%b addr=%h cnt=%0d, want 1 1 %h %0d",
               BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, e.addr, e.cnt);
    else n_pass++;
    hi = 0;
    for (int i = 0; i < 10 && FLUSH; i++) begin
      if (BUSY) hi++;
      tick();
    end
    n_checks++;
    if (hi !== 3 || FLUSH !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL bypass_flush_len: got %0d cycles (flush=%b busy=%b), want 3 (0 0)", hi, FLUSH, BUSY);
    else n_pass++;
  endtask

  task automatic test_stored_flags();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      set_flags(4'b0000);
      tick();
      idle();
      repeat (2) tick();
      n_checks++;
      if (BR_DONE !== 1'b0)
        $display("FAIL stored_idle_done: got %b, want 0", BR_DONE);
      else n_pass++;
      issue((pass == 0) ? 4'd10 : 4'd9, 10'h2C3, 1'b0, 4'b1111);
      tick();
      idle();
      e = sb.pop_front();
      n_checks++;
      if ({BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, FLUSH} !==
          {1'b1, e.taken, e.addr, 16'(e.cnt), e.taken})
        $display("FAIL stored_cond%0d: got done=%b taken=%b addr=%h cnt=%0d flush=%b, want 1 %b %h %0d %b",
                 (pass == 0) ? 10 : 9, BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, FLUSH,
                 e.taken, e.addr, e.cnt, e.taken);
      else n_pass++;
      if (e.taken) drain();
    end
  endtask

  task automatic test_squash();
    exp_t e;
    issue(4'd0, 10'h0AA, 1'b0, 4'b0000);
    tick();
    e = sb.pop_front();
    BR_REQ = 1'b1; BR_COND = 4'd0; BR_TARGET = 10'h3FF;
    FLAG_VALID = 1'b1; {ZF, EQF, GTF, SF} = 4'b1000;
    tick();
    idle();
    n_checks++;
    if ({BR_DONE, BR_TAKEN, TAKEN_CNT, FLUSH, BR_ADDR} !== {1'b0, 1'b0, 16'(e.cnt), 1'b1, e.addr})
      $display("FAIL squash_req: got done=%b taken=%b cnt=%0d flush=%b addr=%h, want 0 0 %0d 1 %h",
               BR_DONE, BR_TAKEN, TAKEN_CNT, FLUSH, BR_ADDR, e.cnt, e.addr);
    else n_pass++;
    repeat (2) tick();
    // Stored Z must still be 0, so a Z branch without fresh flags is not taken.
    issue(4'd1, 10'h111, 1'b0, 4'b0000);
    tick();
    idle();
    e = sb.pop_front();
    n_checks++;
    if ({BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT} !== {1'b1, e.taken, e.addr, 16'(e.cnt)})
      $display("FAIL squash_flags_held: got done=%b taken=%b addr=%h cnt=%0d, want 1 %b %h %0d",
               BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, e.taken, e.addr, e.cnt);
    else n_pass++;
    if (e.taken) drain();
  endtask

  task automatic test_pause();
    exp_t e;
    int   n;
    issue(4'd0, 10'h1FF, 1'b0, 4'b0000);
    tick();
    idle();
    e = sb.pop_front();
    tick();
    ENABLE = 1'b0;
    BR_REQ = 1'b1; FLAG_VALID = 1'b1; {ZF, EQF, GTF, SF} = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({FLUSH, BUSY, BR_DONE, BR_TAKEN, TAKEN_CNT} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'(e.cnt)})
        $display("FAIL pause_hold%0d: got flush=%b busy=%b done=%b taken=%b cnt=%0d, want 1 1 0 0 %0d",
                 i, FLUSH, BUSY, BR_DONE, BR_TAKEN, TAKEN_CNT, e.cnt);
      else n_pass++;
    end
    ENABLE = 1'b1;
    idle();
    n = 0;
    while (n < 10) begin
      tick();
      n++;
      if (!FLUSH) break;
    end
    n_checks++;
    if (n !== 2 || FLUSH !== 1'b0)
      $display("FAIL pause_resume: got drop after %0d enabled cycles (flush=%b), want 2", n, FLUSH);
    else n_pass++;
  endtask

  task automatic test_edge_cases();
    exp_t e;
    issue(4'd13, 10'h333, 1'b1, 4'b1111);
    tick();
    idle();
    e = sb.pop_front();
    n_checks++;
    if ({BR_DONE, BR_TAKEN, BR_ADDR, FLUSH} !== {1'b1, 1'b0, e.addr, 1'b0} || e.taken)
      $display("FAIL reserved_cond13: got done=%b taken=%b addr=%h flush=%b, want 1 0 %h 0",
               BR_DONE, BR_TAKEN, BR_ADDR, FLUSH, e.addr);
    else n_pass++;
    ENABLE = 1'b0;
    BR_REQ = 1'b1; BR_COND = 4'd0; BR_TARGET = 10'h001;
    repeat (2) tick();
    n_checks++;
    if ({BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT} !== {1'b1, 1'b0, e.addr, 16'(e.cnt)})
      $display("FAIL pause_pulse_hold: got done=%b taken=%b addr=%h cnt=%0d, want 1 0 %h %0d",
               BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, e.addr, e.cnt);
    else n_pass++;
    ENABLE = 1'b1;
    idle();
    tick();
    n_checks++;
    if (BR_DONE !== 1'b0)
      $display("FAIL pulse_clear: got done=%b, want 0", BR_DONE);
    else n_pass++;
  endtask

  task automatic test_all_conds();
    exp_t       e;
    logic [3:0] f;
    for (int c = 0; c < 16; c++) begin
      f = 4'($urandom_range(0, 15));
      issue(4'(c), 10'($urandom_range(0, 1023)), 1'b1, f);
      tick();
      idle();
      e = sb.pop_front();
      n_checks++;
      if ({BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT} !== {1'b1, e.taken, e.addr, 16'(e.cnt)})
        $display("FAIL cond%0d_flags%b: got done=%b taken=%b addr=%h cnt=%0d, want 1 %b %h %0d",
                 c, f, BR_DONE, BR_TAKEN, BR_ADDR, TAKEN_CNT, e.taken, e.addr, e.cnt);
      else n_pass++;
      if (e.taken) drain();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    set_flags(4'b0000);
    tick();
    for (int i = 0; i < 6; i++) begin
      // Alternate reserved codes with codes that are false for all-zero flags.
      issue((i % 2 == 0) ? 4'(11 + i / 2) : 4'd1, 10'(i * 37), 1'b0, 4'b0000);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({BR_DONE, BR_TAKEN, BR_ADDR, FLUSH} !== {1'b1, 1'b0, e.addr, 1'b0})
        $display("FAIL b2b_%0d: got done=%b taken=%b addr=%h flush=%b, want 1 0 %h 0",
                 i, BR_DONE, BR_TAKEN, BR_ADDR, FLUSH, e.addr);
      else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    exp_t e;
    int   sm_exp;
    for (int i = 0; i < 3; i++) begin
      issue(4'd0, 10'(100 + i), 1'b0, 4'b0000);
      tick();
      idle();
      e = sb.pop_front();
      sm_exp = (m_cnt > 3) ? 3 : m_cnt;
      n_checks++;
      if ({sm_cnt, sm_taken, sm_done, sm_addr, TAKEN_CNT} !==
          {2'(sm_exp), 1'b1, 1'b1, e.addr, 16'(e.cnt)})
        $display("FAIL saturate_%0d: got small=%0d taken=%b done=%b addr=%h big=%0d, want %0d 1 1 %h %0d",
                 i, sm_cnt, sm_taken, sm_done, sm_addr, TAKEN_CNT, sm_exp, e.addr, e.cnt);
      else n_pass++;
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stored_flags();
    test_squash();
    test_pause();
    test_edge_cases();
    test_all_conds();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000, want finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Sits directly downstream of the ALU flag stage in the IPPro datapath.
- Keeps a registered copy of the flags ZF/EQF/GTF/SF.
- Evaluates a 4-bit condition code against those flags for conditional branch instructions.
- Issues a registered branch-taken pulse with the target address, then drives a pipeline flush for a fixed number of enabled cycles.

Parameters:
PC_WIDTH, 10, width of branch target / program address
FLUSH_DEPTH, 3, number of enabled cycles FLUSH is held after a taken branch (>=1)
CNT_WIDTH, 16, width of saturating taken-branch counter

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  pipeline advance; low = pause, all state held
ZF  in  1  zero flag from flag stage (combinational, current cycle)
EQF  in  1  equal flag
GTF  in  1  greater-than flag
SF  in  1  sign flag
FLAG_VALID  in  1  current flags belong to a flag-setting instruction
BR_REQ  in  1  conditional branch instruction present this cycle
BR_COND  in  4  condition code
BR_TARGET  in  PC_WIDTH  branch destination
BR_TAKEN  out  1  registered pulse: branch taken
BR_ADDR  out  PC_WIDTH  target, valid while BR_TAKEN=1
BR_DONE  out  1  registered pulse: branch resolved (taken or not)
FLUSH  out  1  squash younger pipeline stages
BUSY  out  1  high while in FLUSH state
TAKEN_CNT  out  CNT_WIDTH  saturating count of taken branches

Behaviour:
- Reset (RESET_N=0, async): stored flags=0, BR_TAKEN=0, BR_ADDR=0, BR_DONE=0, FLUSH=0, BUSY=0, TAKEN_CNT=0, state=IDLE, flush counter=0. Reset mid-flush aborts the flush immediately.
- Flag register: on a rising edge with ENABLE=1 and FLAG_VALID=1, capture ZF/EQF/GTF/SF. Otherwise hold.
- Effective flags for evaluation:
  - FLAG_VALID=1 in the same cycle: incoming flags (bypass).
  - Otherwise: stored flags.
- Condition codes:
  - 0 always
  - 1 Z
  - 2 ~Z
  - 3 EQ
  - 4 ~EQ
  - 5 GT
  - 6 ~GT
  - 7 S
  - 8 ~S
  - 9 GT|EQ
  - 10 ~GT&~EQ
  - 11-15 reserved: never taken, still produce BR_DONE.
- ENABLE=0: every register holds, including pulse outputs, state and flush counter. Inputs are ignored.
- States: IDLE, FLUSH.
- IDLE, ENABLE=1, BR_REQ=1: at the next edge BR_DONE=1 and BR_TAKEN=cond.
  - Taken:
    - BR_ADDR <= BR_TARGET
    - FLUSH <= 1, BUSY <= 1
    - counter <= FLUSH_DEPTH-1
    - TAKEN_CNT increments, saturating at all-ones
    - state <= FLUSH
  - Not taken: BR_ADDR holds its previous value and the state stays IDLE.
- IDLE with no BR_REQ: BR_TAKEN and BR_DONE return to 0 on the next enabled edge.
- FLUSH state, each enabled edge:
  - BR_TAKEN <= 0, BR_DONE <= 0.
  - Counter=0: FLUSH <= 0, BUSY <= 0, state <= IDLE.
  - Otherwise: decrement the counter.
- FLUSH is therefore high for exactly FLUSH_DEPTH enabled cycles, starting the cycle BR_TAKEN is high.
- BR_REQ in FLUSH state belongs to a squashed instruction and is ignored: no BR_DONE, no count.
- FLAG_VALID in FLUSH state is also from a squashed instruction; the flag register does not update.
- Latency: branch resolved at input cycle n, outputs visible after edge n+1 (one enabled cycle).
- BR_REQ and FLAG_VALID together in IDLE: bypassed flags are used and the flag register also updates.
- Back-to-back BR_REQ in IDLE, all not taken: BR_DONE stays high continuously, one resolution per cycle.

Test Plan:
- Reset behaviour: RESET_N low mid-flush (FLUSH=1) -> all outputs 0 asynchronously. After release, BR_REQ with cond 0 and target 0x055 -> BR_TAKEN=1, BR_ADDR=0x055 one cycle later.
- Bypass case: FLAG_VALID=1, ZF=1 with BR_REQ=1, BR_COND=1, target 0x120 in the same cycle -> taken, BR_ADDR=0x120, FLUSH high 3 cycles, TAKEN_CNT=1.
- Stored flags: FLAG_VALID=1, GTF=0, EQF=0, then 2 idle cycles, then BR_REQ with cond 10 -> taken. Same sequence with cond 9 -> BR_DONE=1, BR_TAKEN=0, FLUSH=0.
- Squash in FLUSH: taken branch, then BR_REQ (cond 0) and FLAG_VALID with ZF=1 during FLUSH -> no second BR_DONE, TAKEN_CNT unchanged, stored ZF unchanged.
- Pause: ENABLE=0 for 4 cycles during FLUSH (counter at 1) -> FLUSH stays high throughout; after re-enable it drops after exactly 2 more enabled cycles.
- Edge cases: cond 13 -> not taken with BR_DONE=1. Force TAKEN_CNT to 0xFFFF via 65535 taken branches (or a CNT_WIDTH=2 build) -> counter saturates and does not wrap.
